udma_uart_xfer_seq: RTL and testbench

//  Hardware sequencer that drives the UART uDMA cfg bus on behalf of a local master (e.g. boot ROM, debug unit).

---
 rtl/udma_uart_pkg.sv | 49 ++++
 rtl/udma_uart_seq_timer.sv | 43 ++++
 rtl/udma_uart_xfer_seq.sv | 170 +++++++++++++++++
 tb/tb_udma_uart_xfer_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_uart_pkg.sv
// Shared definitions for the UART uDMA channel: cfg register map, CFG bit
// positions, error flag indices and the transfer sequencer state encoding.
package udma_uart_pkg;

  localparam logic [4:0] REG_RX_SADDR  = 5'h00;
  localparam logic [4:0] REG_RX_SIZE   = 5'h01;
  localparam logic [4:0] REG_RX_CFG    = 5'h02;
  localparam logic [4:0] REG_RX_INTCFG = 5'h03;
  localparam logic [4:0] REG_TX_SADDR  = 5'h04;
  localparam logic [4:0] REG_TX_SIZE   = 5'h05;
  localparam logic [4:0] REG_TX_CFG    = 5'h06;
  localparam logic [4:0] REG_TX_INTCFG = 5'h07;
  localparam logic [4:0] REG_STATUS    = 5'h08;
  localparam logic [4:0] REG_UART_SETUP = 5'h09;
  localparam logic [4:0] REG_ERROR     = 5'h0A;
  localparam logic [4:0] REG_IRQ_EN    = 5'h0B;
  localparam logic [4:0] REG_VALID     = 5'h0C;
  localparam logic [4:0] REG_DATA      = 5'h0D;

  localparam int CFG_CONT = 0;
  localparam int CFG_EN   = 4;
  localparam int CFG_PEND = 5;
  localparam int CFG_CLR  = 6;

  // done_err bit positions: {timeout,abort,parity,overflow}
  localparam int ERR_OVF   = 0;
  localparam int ERR_PAR   = 1;
  localparam int ERR_ABORT = 2;
  localparam int ERR_TMO   = 3;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_W_SETUP   = 4'd1,
    S_W_SADDR   = 4'd2,
    S_W_SIZE    = 4'd3,
    S_W_CFG     = 4'd4,
    S_GAP       = 4'd5,
    S_POLL      = 4'd6,
    S_R_ERR     = 4'd7,
    S_DONE      = 4'd8,
    S_ABORT_CLR = 4'd9
  } seq_state_e;

  // Per-channel register block base: RX block sits at 0x00, TX at 0x04.
  function automatic logic [4:0] chan_base(input logic rx);
    return rx ? REG_RX_SADDR : REG_TX_SADDR;
  endfunction

endpackage

// File: rtl/udma_uart_seq_timer.sv
// Poll pacing for the transfer sequencer: a gap down-counter that reloads
// whenever the sequencer is outside GAP, and a poll up-counter.
module udma_uart_seq_timer #(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gap_run,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic gap_done,
  output logic poll_last
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      if (!gap_run)
        gap_cnt <= GW'(POLL_GAP - 1);
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      if (poll_clr)
        poll_cnt <= '0;
      else if (poll_inc)
        poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign gap_done  = (gap_cnt == '0);
  // true during the final permitted poll
  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));

endmodule

// File: rtl/udma_uart_xfer_seq.sv
// Programs one UART uDMA channel transfer over the cfg bus and polls it to
// completion, reporting {timeout,abort,parity,overflow} on the done port.
module udma_uart_xfer_seq
  import udma_uart_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 4,
  parameter int POLL_MAX       = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_dir_i,
  input  logic [31:0]               req_setup_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic                      req_cont_i,
  input  logic                      abort_i,
  output logic                      done_valid_o,
  output logic [3:0]                done_err_o,
  input  logic                      done_ready_i,
  output logic                      busy_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i
);

  seq_state_e                state;
  logic                      dir, cont;
  logic [31:0]               setup, setup_cache;
  logic                      cache_vld;
  logic [L2_AWIDTH_NOAL-1:0] saddr;
  logic [TRANS_SIZE-1:0]     size;
  logic [3:0]                err;
  logic [4:0]                base;
  logic                      hs, chan_done, tmo, gap_done, poll_last;

  assign base      = chan_base(dir);
  assign hs        = cfg_valid_o & cfg_ready_i;
  assign chan_done = (cfg_data_i[CFG_PEND:CFG_EN] == 2'b00);
  assign tmo       = !chan_done && poll_last;

  assign req_ready_o  = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);
  assign done_valid_o = (state == S_DONE);
  assign done_err_o   = (state == S_DONE) ? err : 4'b0;

  udma_uart_seq_timer #(
    .POLL_GAP (POLL_GAP),
    .POLL_MAX (POLL_MAX)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .gap_run   (state == S_GAP),
    .poll_clr  (state == S_IDLE),
    .poll_inc  ((state == S_POLL) && hs),
    .gap_done  (gap_done),
    .poll_last (poll_last)
  );

  // Bus fields are decoded from state and registered request fields only,
  // so they hold steady across cfg_ready_i stalls.
  always_comb begin
    cfg_valid_o = 1'b0;
    cfg_rwn_o   = 1'b0;
    cfg_addr_o  = base + 5'd2;
    cfg_data_o  = '0;
    case (state)
      S_W_SETUP: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_UART_SETUP;
        cfg_data_o  = setup;
      end
      S_W_SADDR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base;
        cfg_data_o  = 32'(saddr);
      end
      S_W_SIZE: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base + 5'd1;
        cfg_data_o  = 32'(size);
      end
      S_W_CFG: begin
        cfg_valid_o          = 1'b1;
        cfg_data_o[CFG_EN]   = 1'b1;
        cfg_data_o[CFG_CONT] = cont;
      end
      S_POLL: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
      end
      S_R_ERR: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = REG_ERROR;
      end
      S_ABORT_CLR: begin
        cfg_valid_o         = 1'b1;
        cfg_data_o[CFG_CLR] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      dir         <= 1'b0;
      cont        <= 1'b0;
      setup       <= '0;
      setup_cache <= '0;
      cache_vld   <= 1'b0;
      saddr       <= '0;
      size        <= '0;
      err         <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid_i) begin
          dir   <= req_dir_i;
          cont  <= req_cont_i;
          setup <= req_setup_i;
          saddr <= req_addr_i;
          size  <= req_size_i;
          err   <= '0;
          state <= (cache_vld && setup_cache == req_setup_i) ? S_W_SADDR : S_W_SETUP;
        end
        S_W_SETUP: if (hs) begin
          setup_cache <= setup;
          cache_vld   <= 1'b1;
          state       <= S_W_SADDR;
        end
        S_W_SADDR: if (hs) state <= S_W_SIZE;
        S_W_SIZE:  if (hs) state <= S_W_CFG;
        S_W_CFG:   if (hs) state <= cont ? S_DONE : S_GAP;
        S_GAP: begin
          if (abort_i) begin
            err[ERR_ABORT] <= 1'b1;
            state          <= S_ABORT_CLR;
          end else if (gap_done) begin
            state <= S_POLL;
          end
        end
        S_POLL: if (hs) begin
          if (abort_i) err[ERR_ABORT] <= 1'b1;
          if (tmo)     err[ERR_TMO]   <= 1'b1;
          if (abort_i || tmo) state <= S_ABORT_CLR;
          else if (chan_done) state <= S_R_ERR;
          else                state <= S_GAP;
        end
        S_ABORT_CLR: if (hs) state <= S_R_ERR;
        S_R_ERR: if (hs) begin
          err[ERR_PAR:ERR_OVF] <= cfg_data_i[1:0];
          state                <= S_DONE;
        end
        S_DONE: if (done_ready_i) begin
          err   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_uart_xfer_seq.sv
// Directed bench for udma_uart_xfer_seq with a behavioural cfg-bus
// peripheral that logs every completed access.
module tb_udma_uart_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_dir_i = 1'b0, req_cont_i = 1'b0;
  logic [31:0] req_setup_i = '0;
  logic [11:0] req_addr_i = '0;
  logic [15:0] req_size_i = '0;
  logic        abort_i = 1'b0, done_valid_o, done_ready_i = 1'b0, busy_o;
  logic [3:0]  done_err_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o, cfg_data_i;
  logic        cfg_valid_o, cfg_rwn_o, cfg_ready_i = 1'b1;

  always #5 clk = ~clk;

  udma_uart_xfer_seq #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(2), .POLL_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_dir_i(req_dir_i),
    .req_setup_i(req_setup_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i),
    .req_cont_i(req_cont_i), .abort_i(abort_i),
    .done_valid_o(done_valid_o), .done_err_o(done_err_o), .done_ready_i(done_ready_i),
    .busy_o(busy_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i)
  );

  int total = 0, bad = 0;
  int pend = 0, stab_bad = 0;
  bit never_idle = 0, stall_en = 0;
  logic [31:0] err_val = '0, rd;
  logic [63:0] acc_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic rwn, input logic [4:0] a, input logic [31:0] d);
    return {26'd0, rwn, a, d};
  endfunction

  // Peripheral: CFG reads show en+pending until pend runs out; garbage while stalled.
  always_comb begin
    rd = '0;
    case (cfg_addr_o)
      5'h02, 5'h06: rd = (never_idle || pend > 0) ? 32'h30 : 32'h0;
      5'h0A:        rd = err_val;
      default:      rd = '0;
    endcase
    cfg_data_i = cfg_ready_i ? rd : 32'hFFFF_FFFF;
  end

  initial begin
    logic        hs, stall_prev, hs_rd;
    logic [4:0]  hs_addr;
    logic [37:0] prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      hs = cfg_valid_o && cfg_ready_i && !rst_i;
      if (stall_en && stall_prev &&
          (!cfg_valid_o || {cfg_rwn_o, cfg_addr_o, cfg_data_o} != prev))
        stab_bad++;
      stall_prev = cfg_valid_o && !cfg_ready_i && !rst_i;
      prev = {cfg_rwn_o, cfg_addr_o, cfg_data_o};
      hs_rd = cfg_rwn_o;
      hs_addr = cfg_addr_o;
      if (hs) acc_log.push_back(ent(cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? cfg_data_i : cfg_data_o));
      @(posedge clk);
      #1;
      if (hs && hs_rd && (hs_addr == 5'h02 || hs_addr == 5'h06) && pend > 0) pend--;
      cfg_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic do_req(input logic dir, input logic [31:0] setup, input logic [11:0] addr,
                        input logic [15:0] size, input logic cont);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    chk("req_ready_wait", {63'd0, req_ready_o}, 64'd1);
    req_dir_i = dir; req_setup_i = setup; req_addr_i = addr;
    req_size_i = size; req_cont_i = cont; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic [3:0] e);
    n = 0;
    e = 4'hF;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done_valid_o) begin
        n = i;
        e = done_err_o;
        done_ready_i = 1'b1;
        @(posedge clk);
        #1 done_ready_i = 1'b0;
        return;
      end
    end
    chk("done_wait_expired", 64'd1, 64'd0);
  endtask

  task automatic exp_acc(input string tag, input logic rwn, input logic [4:0] a, input logic [31:0] d);
    logic [63:0] got;
    got = (acc_log.size() == 0) ? '1 : acc_log.pop_front();
    chk(tag, got, ent(rwn, a, d));
  endtask

  localparam logic [31:0] SETUP_A = 32'h0003_5A01;
  localparam logic [31:0] SETUP_B = 32'h0003_5A02;

  initial begin
    int n;
    logic [3:0] e;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_cfg_valid", {63'd0, cfg_valid_o}, 64'd0);
    chk("rst_done", {59'd0, done_valid_o, done_err_o}, 64'd0);
    rst_i = 1'b0;

    // TX, pending for two polls
    pend = 2;
    do_req(1'b0, SETUP_A, 12'h100, 16'd16, 1'b0);
    wait_done(n, e);
    exp_acc("t1_setup", 0, 5'h09, SETUP_A);
    exp_acc("t1_saddr", 0, 5'h04, 32'h100);
    exp_acc("t1_size",  0, 5'h05, 32'd16);
    exp_acc("t1_cfg",   0, 5'h06, 32'h10);
    exp_acc("t1_poll0", 1, 5'h06, 32'h30);
    exp_acc("t1_poll1", 1, 5'h06, 32'h30);
    exp_acc("t1_poll2", 1, 5'h06, 32'h00);
    exp_acc("t1_rerr",  1, 5'h0A, 32'h00);
    chk("t1_log_empty", acc_log.size(), 0);
    chk("t1_err", {60'd0, e}, 64'd0);

    // Same setup is cached; 3 writes + 2 gap + poll + rerr + done
    do_req(1'b0, SETUP_A, 12'h100, 16'd16, 1'b0);
    wait_done(n, e);
    exp_acc("t2_saddr", 0, 5'h04, 32'h100);
    exp_acc("t2_size",  0, 5'h05, 32'd16);
    exp_acc("t2_cfg",   0, 5'h06, 32'h10);
    exp_acc("t2_poll",  1, 5'h06, 32'h00);
    exp_acc("t2_rerr",  1, 5'h0A, 32'h00);
    chk("t2_latency", n, 8);
    chk("t2_err", {60'd0, e}, 64'd0);

    do_req(1'b0, SETUP_B, 12'h100, 16'd16, 1'b0);
    wait_done(n, e);
    exp_acc("t3_setup", 0, 5'h09, SETUP_B);
    acc_log.delete();

    // RX continuous: no polling, done right after the CFG write
    do_req(1'b1, SETUP_B, 12'h020, 16'd8, 1'b1);
    wait_done(n, e);
    exp_acc("t4_saddr", 0, 5'h00, 32'h20);
    exp_acc("t4_size",  0, 5'h01, 32'd8);
    exp_acc("t4_cfg",   0, 5'h02, 32'h11);
    chk("t4_log_empty", acc_log.size(), 0);
    chk("t4_latency", n, 4);
    chk("t4_err", {60'd0, e}, 64'd0);

    // Random cfg stalls
    stall_en = 1; pend = 1;
    do_req(1'b0, SETUP_B, 12'hABC, 16'h1234, 1'b0);
    wait_done(n, e);
    stall_en = 0;
    exp_acc("t5_saddr", 0, 5'h04, 32'hABC);
    exp_acc("t5_size",  0, 5'h05, 32'h1234);
    exp_acc("t5_cfg",   0, 5'h06, 32'h10);
    exp_acc("t5_poll0", 1, 5'h06, 32'h30);
    exp_acc("t5_poll1", 1, 5'h06, 32'h00);
    exp_acc("t5_rerr",  1, 5'h0A, 32'h00);
    chk("t5_stable", stab_bad, 0);
    chk("t5_err", {60'd0, e}, 64'd0);

    // Timeout after POLL_MAX=4 polls
    never_idle = 1;
    do_req(1'b0, SETUP_B, 12'h100, 16'd16, 1'b0);
    wait_done(n, e);
    exp_acc("t6_saddr", 0, 5'h04, 32'h100);
    exp_acc("t6_size",  0, 5'h05, 32'd16);
    exp_acc("t6_cfg",   0, 5'h06, 32'h10);
    for (int i = 0; i < 4; i++) exp_acc($sformatf("t6_poll%0d", i), 1, 5'h06, 32'h30);
    exp_acc("t6_clr",   0, 5'h06, 32'h40);
    exp_acc("t6_rerr",  1, 5'h0A, 32'h00);
    chk("t6_err", {60'd0, e}, 64'h8);

    // Abort during GAP, peripheral reports parity+overflow
    err_val = 32'h3;
    do_req(1'b0, SETUP_B, 12'h100, 16'd16, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy_o && !cfg_valid_o && !done_valid_o) break;
    end
    abort_i = 1'b1;
    wait_done(n, e);
    abort_i = 1'b0;
    err_val = 32'h0;
    exp_acc("t7_saddr", 0, 5'h04, 32'h100);
    exp_acc("t7_size",  0, 5'h05, 32'd16);
    exp_acc("t7_cfg",   0, 5'h06, 32'h10);
    exp_acc("t7_clr",   0, 5'h06, 32'h40);
    exp_acc("t7_rerr",  1, 5'h0A, 32'h03);
    chk("t7_err", {60'd0, e}, 64'h7);
    never_idle = 0;

    // done_valid held while unacknowledged; pending request not taken
    do_req(1'b1, SETUP_B, 12'h020, 16'd8, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_valid_o) break;
    end
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t8_hold%0d", i), {62'd0, done_valid_o, req_ready_o}, 64'b10);
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    done_ready_i = 1'b1;
    @(posedge clk);
    #1 done_ready_i = 1'b0;
    @(negedge clk);
    chk("t8_after_ack", {62'd0, done_valid_o, req_ready_o}, 64'b01);
    acc_log.delete();

    // Reset mid-POLL
    never_idle = 1;
    do_req(1'b0, SETUP_B, 12'h100, 16'd16, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_valid_o && cfg_rwn_o && cfg_addr_o == 5'h06) break;
    end
    rst_i = 1'b1;
    @(negedge clk);
    chk("t9_idle", {61'd0, cfg_valid_o, busy_o, req_ready_o}, 64'b001);
    rst_i = 1'b0;
    never_idle = 0;
    acc_log.delete();
    do_req(1'b1, SETUP_B, 12'h020, 16'd8, 1'b1);
    wait_done(n, e);
    exp_acc("t9_cache_inval", 0, 5'h09, SETUP_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
